iob_uart_master: RTL and testbench
==================================

IOB_UART_MASTER -- requirements
Module: iob_uart_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width (only 32 supported).
REQ-002 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-003 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (legal range 4..65535).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rxd  input  1  UART serial input, asynchronous to clk.
REQ-007 SHALL have port txd  output  1  UART serial output.
REQ-008 SHALL have port valid  output  1  IOb-native request valid (initiator side).
REQ-009 SHALL have port address  output  ADDR_W  request byte address.
REQ-010 SHALL have port wdata  output  DATA_W  write data.
REQ-011 SHALL have port wstrb  output  DATA_W/8  write strobes; 0 means read.
REQ-012 SHALL have port rdata  input  DATA_W  read data, valid in the ready cycle.
REQ-013 SHALL have port ready  input  1  responder completion, one cycle per request.

Function
REQ-014 SHALL implement UART 8N1, LSB first, idle high, on both rxd and txd.
REQ-015 SHALL synchronise rxd through two flops before any use.
REQ-016 RX SHALL start on a synchronised 1->0 transition while idle, recheck start bit low at CLK_DIV/2 (abort to idle if high), then sample each data bit and the stop bit every CLK_DIV cycles.
REQ-017 RX SHALL discard a byte whose stop bit samples 0 (framing error); parser state unchanged.
REQ-018 Parser FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-019 IDLE: byte 0x57 ('W') -> ADDR with op=write; 0x52 ('R') -> ADDR with op=read; any other byte ignored, stay IDLE.
REQ-020 ADDR SHALL collect 4 bytes little-endian (first byte = address[7:0]); after 4th: write -> DATA, read -> BUS.
REQ-021 DATA SHALL collect 4 bytes little-endian into wdata; after 4th -> BUS.
REQ-022 BUS SHALL assert valid in the cycle after entry, with wstrb=4'hF for write or 4'h0 for read, address/wdata stable, and hold all until the cycle ready=1.
REQ-023 valid SHALL be 0 in the cycle after the ready cycle; read captures rdata in the ready cycle; -> RESP.
REQ-024 ready while valid=0 SHALL be ignored.
REQ-025 RESP write: transmit one byte 0x06; RESP read: transmit the 4 captured rdata bytes little-endian, back-to-back (next start bit immediately after previous stop bit); then -> IDLE.
REQ-026 Bytes completed on RX while in BUS or RESP SHALL be dropped (no buffering).
REQ-027 TX frame SHALL be exactly 10*CLK_DIV cycles: start, 8 data, stop.
REQ-028 No request SHALL ever be issued with an incomplete address or data field.

Reset
REQ-029 While rst=1 at a clock edge: txd=1, valid=0, address=0, wdata=0, wstrb=0, FSM=IDLE, RX/TX idle, counters cleared.
REQ-030 rst mid-frame or mid-request SHALL abandon all progress; an outstanding request is dropped and a later ready ignored; behaviour resumes from IDLE on the next cycle after rst deasserts.

Verification (CLK_DIV=8)
REQ-031 Write: rxd sends 57 10 00 00 80 EF BE AD DE -> one request address=0x80000010, wdata=0xDEADBEEF, wstrb=F, valid held until ready; then txd frame 0x06.
REQ-032 Read: rxd sends 52 04 00 00 00, responder returns rdata=0x12345678 after 3 wait cycles -> wstrb=0, one request, txd bytes 78 56 34 12, each frame 80 cycles, no gaps.
REQ-033 Noise: bytes 00 FF 41 then a valid write command -> exactly one request, for the write only.
REQ-034 Framing error: address byte sent with stop bit 0 -> byte dropped; next 4 good bytes complete the address; request uses them.
REQ-035 Glitch: rxd low for 2 cycles while idle -> no byte received, FSM stays IDLE.
REQ-036 Reset: assert rst for 1 cycle during DATA phase and during BUS (ready held off) -> valid=0, txd=1, no response byte; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/iob_uart_master.sv
// UART-to-IOb bridge: a host on rxd/txd issues single-word reads
// and writes on an IOb-native initiator port.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   rxd / txd             UART 8N1 serial in / out (idle high, LSB first)
//   valid, address,       IOb request (wstrb=0 means read)
//   wdata, wstrb
//   rdata, ready          IOb response (rdata valid in the ready cycle)
//
// Host protocol: 'W' a0 a1 a2 a3 d0 d1 d2 d3 -> reply 0x06
//                'R' a0 a1 a2 a3             -> reply r0 r1 r2 r3
module iob_uart_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int CLK_DIV = 868
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    output logic                txd,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready
);

    localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    rx_state_t   rx_state, rx_state_n;
    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_tick;
    logic        rx_byte_vld;
    logic [7:0]  rx_byte;

    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_byte = rx_sh;

    always_comb begin
        rx_state_n  = rx_state;
        rx_byte_vld = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_s3 && !rx_s2) rx_state_n = RX_START;
            // a start bit that is high again at mid-bit is a glitch
            RX_START: if (rx_tick) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_n  = RX_IDLE;
                    rx_byte_vld = rx_s2;
                end
            end
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= HALF_END;
                rx_bit <= 3'd0;
            end else if (rx_tick) begin
                rx_cnt <= BIT_END;
                if (rx_state == RX_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    // ---------------- UART transmitter ----------------
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    tx_state_t   tx_state, tx_state_n;
    logic [9:0]  tx_sh;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic        tx_last;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;

    // Accepting a byte in the final stop-bit cycle keeps frames gapless.
    assign tx_last  = (tx_state == TX_BUSY) && (tx_cnt == 16'd0)
                    && (tx_bit == 4'd9);
    assign tx_ready = (tx_state == TX_IDLE) || tx_last;
    assign txd      = tx_sh[0];

    always_comb begin
        tx_state_n = tx_state;
        if (tx_start && tx_ready) tx_state_n = TX_BUSY;
        else if (tx_last)         tx_state_n = TX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '1;
            tx_cnt   <= 16'd0;
            tx_bit   <= 4'd0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_start && tx_ready) begin
                tx_sh  <= {1'b1, tx_data, 1'b0};
                tx_cnt <= BIT_END;
                tx_bit <= 4'd0;
            end else if (tx_state == TX_BUSY) begin
                if (tx_cnt == 16'd0) begin
                    tx_sh  <= {1'b1, tx_sh[9:1]};
                    tx_cnt <= BIT_END;
                    tx_bit <= tx_bit + 4'd1;
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // ---------------- command parser ----------------
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state, state_n;
    logic        op_wr;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_sh;
    logic [31:0] data_sh;
    logic [31:0] rsp_sh;
    logic [2:0]  rsp_left;
    logic        issue;

    assign address = ADDR_W'(addr_sh);
    assign wdata   = DATA_W'(data_sh);
    assign tx_data = rsp_sh[7:0];
    assign issue   = (state_n == BUS) && (state != BUS);

    always_comb begin
        state_n  = state;
        tx_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_byte_vld &&
                    (rx_byte == 8'h57 || rx_byte == 8'h52))
                    state_n = ADDR;
            end
            ADDR: begin
                if (rx_byte_vld && byte_cnt == 2'd3)
                    state_n = op_wr ? DATA : BUS;
            end
            DATA: begin
                if (rx_byte_vld && byte_cnt == 2'd3)
                    state_n = BUS;
            end
            BUS: if (valid && ready) state_n = RESP;
            RESP: begin
                // leave only once the last reply byte is on the wire
                if (rsp_left != 3'd0) tx_start = 1'b1;
                else if (tx_ready)    state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            byte_cnt <= 2'd0;
            addr_sh  <= 32'd0;
            data_sh  <= 32'd0;
            rsp_sh   <= 32'd0;
            rsp_left <= 3'd0;
            valid    <= 1'b0;
            wstrb    <= '0;
        end else begin
            state <= state_n;
            if (issue) begin
                valid <= 1'b1;
                wstrb <= op_wr ? '1 : '0;
            end
            unique case (state)
                IDLE: begin
                    if (rx_byte_vld) begin
                        op_wr    <= (rx_byte == 8'h57);
                        byte_cnt <= 2'd0;
                    end
                end
                ADDR: begin
                    if (rx_byte_vld) begin
                        addr_sh  <= {rx_byte, addr_sh[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (rx_byte_vld) begin
                        data_sh  <= {rx_byte, data_sh[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                BUS: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        wstrb <= '0;
                        if (op_wr) begin
                            rsp_sh   <= 32'h06;
                            rsp_left <= 3'd1;
                        end else begin
                            rsp_sh   <= 32'(rdata);
                            rsp_left <= 3'd4;
                        end
                    end
                end
                RESP: begin
                    if (tx_start && tx_ready) begin
                        rsp_sh   <= rsp_sh >> 8;
                        rsp_left <= rsp_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_uart_master.sv
// Scoreboard bench for iob_uart_master: a host model drives rxd, a
// responder checks bus requests, a UART monitor decodes txd.
module tb_iob_uart_master;

    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        txd;
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata = 32'd0;
    logic        ready;
    logic        ready_r = 1'b0;
    logic        stray = 1'b0;

    assign ready = ready_r | stray;

    always #5 clk = ~clk;

    iob_uart_master #(
        .DATA_W (32),
        .ADDR_W (32),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .txd    (txd),
        .valid  (valid),
        .address(address),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .rdata  (rdata),
        .ready  (ready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          wait_n;
        logic [31:0] rd;
    } req_t;

    typedef struct {
        logic [7:0] b;
        bit         contig;
        bit         last;
    } txe_t;

    req_t   req_q[$];
    txe_t   tx_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     n_req = 0;
    int     exp_req = 0;
    int     outstanding = 0;
    bit     hold_off = 1'b0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (2 * CLK_DIV) @(negedge clk);
    endtask

    // Reference model: a command yields one request and a reply stream.
    task automatic issue_cmd(input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int wait_n,
                             input logic [31:0] rd, input int bad_at,
                             input bit gaps);
        logic [7:0] bytes[$];
        req_t r;
        r = '{wr: wr, addr: a, data: d, wait_n: wait_n, rd: rd};
        req_q.push_back(r);
        exp_req++;
        outstanding++;
        if (wr) begin
            tx_q.push_back('{b: 8'h06, contig: 1'b0, last: 1'b1});
        end else begin
            for (int i = 0; i < 4; i++)
                tx_q.push_back('{b: rd[8*i +: 8], contig: (i > 0),
                                 last: (i == 3)});
        end
        bytes.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) bytes.push_back(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) bytes.push_back(d[8*i +: 8]);
        foreach (bytes[i]) begin
            if (i == bad_at) uart_send(8'($urandom), 1'b0);
            uart_send(bytes[i], 1'b1);
            if (gaps) repeat ($urandom_range(0, 20)) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while ((outstanding != 0 || req_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(outstanding + req_q.size()), 32'd0);
        if (t >= 5000) begin
            req_q.delete();
            tx_q.delete();
            outstanding = 0;
        end
        repeat (3 * CLK_DIV) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_wstrb", 32'(wstrb), 32'd0);
    endtask

    // Responder / request checker
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && !hold_off) begin
                n_req++;
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_req: address %h wstrb %h",
                             address, wstrb);
                    r = '{wr: 1'b0, addr: 32'd0, data: 32'd0,
                          wait_n: 0, rd: 32'd0};
                end else begin
                    r = req_q.pop_front();
                    check("req_addr", address, r.addr);
                    check("req_wstrb", 32'(wstrb), r.wr ? 32'hF : 32'h0);
                    if (r.wr) check("req_wdata", wdata, r.data);
                end
                for (int k = 0; k < r.wait_n; k++) begin
                    @(negedge clk);
                    check("valid_hold", 32'(valid), 32'd1);
                    check("addr_hold", address, r.addr);
                end
                rdata   = r.rd;
                ready_r = 1'b1;
                @(negedge clk);
                ready_r = 1'b0;
                rdata   = $urandom;
                check("valid_drop", 32'(valid), 32'd0);
            end
        end
    end

    // UART monitor on txd
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       sb, st;
        longint     t0, last_start;
        txe_t       e;
        prev = 1'b1;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd === 1'b0) begin
                t0 = cyc;
                repeat (CLK_DIV / 2) @(negedge clk);
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                st = txd;
                if (tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_tx: byte %h", b);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_start", 32'(sb), 32'd0);
                    check("tx_byte", 32'(b), 32'(e.b));
                    check("tx_stop", 32'(st), 32'd1);
                    if (e.contig)
                        check("tx_gap", 32'(t0 - last_start),
                              32'(10 * CLK_DIV));
                    if (e.last) outstanding--;
                end
                last_start = t0;
            end
            prev = txd;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_address", address, 32'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_wstrb", 32'(wstrb), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // directed write
        issue_cmd(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'd0, -1, 1'b0);
        wait_done();

        // directed read, 3 wait cycles, gapless reply
        issue_cmd(1'b0, 32'h0000_0004, 32'd0, 3, 32'h1234_5678, -1, 1'b0);
        wait_done();

        // noise bytes ahead of a command
        uart_send(8'h00, 1'b1);
        uart_send(8'hFF, 1'b1);
        uart_send(8'h41, 1'b1);
        issue_cmd(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 0, 32'd0, -1, 1'b0);
        wait_done();

        // framing error on the second address byte
        issue_cmd(1'b0, 32'hA5A5_0102, 32'd0, 1, 32'h0BAD_C0DE, 2, 1'b0);
        wait_done();

        // short glitch while idle
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (5 * CLK_DIV) @(negedge clk);
        check("glitch_valid", 32'(valid), 32'd0);
        issue_cmd(1'b1, 32'h0000_0020, 32'h0000_0057, 1, 32'd0, -1, 1'b0);
        wait_done();

        // reset during DATA phase
        uart_send(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) uart_send(8'h11, 1'b1);
        uart_send(8'h22, 1'b1);
        uart_send(8'h33, 1'b1);
        pulse_rst();
        check("rst_address", address, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        repeat (30 * CLK_DIV) @(negedge clk);

        // reset during BUS with ready held off
        hold_off = 1'b1;
        uart_send(8'h52, 1'b1);
        uart_send(8'h78, 1'b1);
        uart_send(8'h56, 1'b1);
        uart_send(8'h34, 1'b1);
        uart_send(8'h12, 1'b1);
        t = 0;
        while (valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bus_valid", 32'(valid), 32'd1);
        check("bus_addr", address, 32'h1234_5678);
        check("bus_wstrb", 32'(wstrb), 32'd0);
        pulse_rst();
        hold_off = 1'b0;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (30 * CLK_DIV) @(negedge clk);
        check("post_rst_valid", 32'(valid), 32'd0);
        check("post_rst_txd", 32'(txd), 32'd1);

        // fresh command after reset
        issue_cmd(1'b0, 32'h0000_0040, 32'd0, 2, 32'h89AB_CDEF, -1, 1'b0);
        wait_done();

        // randomized commands
        for (int n = 0; n < 12; n++) begin
            issue_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
                      $urandom_range(0, 6), $urandom, -1, 1'b1);
            wait_done();
        end

        check("req_count", 32'(n_req), 32'(exp_req));
        check("tx_q_empty", 32'(tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
